// File: rtl/cpu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_pkg: shared fetch-side types, instruction width and NOP constant  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package cpu_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_e;

  // A byte address is unusable if it is not word aligned or its word index falls outside the array.
  function automatic logic pc_bad(input logic [31:0] pc, input int unsigned depth);
    return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_mem_array.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | inst_mem_array: DEPTH x 32 storage, sync write, combinational read    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module inst_mem_array
  import cpu_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [INST_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [INST_W-1:0]        rdata_o
);

  logic [INST_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/inst_mem_resp.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | inst_mem_resp: fixed-latency instruction fetch responder with preload |
// | Optional one-entry next-line buffer: define INST_MEM_PREFETCH_EN.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module inst_mem_resp
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_pc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [INST_W-1:0] resp_inst,
  output logic              resp_err,
  input  logic              load_en,
  input  logic [31:0]       load_addr,
  input  logic [INST_W-1:0] load_data
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = 3;

  fetch_state_e      state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              resp_valid_q, resp_err_q, hold_err_q;
  logic [INST_W-1:0] resp_inst_q, hold_inst_q;

  logic              w_accept, w_req_err, w_load_ok;
  logic [INST_W-1:0] w_req_inst, w_rdata;
  logic [AW-1:0]     w_raddr;
  logic              w_pf_hit, w_pf_err;
  logic [INST_W-1:0] w_pf_inst;

  assign req_ready  = (state_q == IDLE) && !rst;
  assign w_accept   = req_valid && req_ready;
  assign w_req_err  = pc_bad(req_pc, DEPTH);
  assign w_req_inst = w_req_err ? NOP : w_rdata;
  assign w_load_ok  = load_en && !pc_bad(load_addr, DEPTH);

  inst_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk    (clk),
    .we_i   (w_load_ok),
    .waddr_i(load_addr[AW+1:2]),
    .wdata_i(load_data),
    .raddr_i(w_raddr),
    .rdata_o(w_rdata)
  );

`ifdef INST_MEM_PREFETCH_EN
  logic              pf_valid_q, pf_err_q;
  logic [31:0]       pf_tag_q, pc_q;
  logic [INST_W-1:0] pf_inst_q;
  logic [31:0]       w_next_pc;
  logic              w_next_err, w_done;

  assign w_next_pc  = pc_q + 32'd4;
  assign w_next_err = pc_bad(w_next_pc, DEPTH);
  assign w_done     = (state_q == RESP) && resp_ready;
  assign w_pf_hit   = pf_valid_q && (req_pc == pf_tag_q);
  assign w_pf_inst  = pf_inst_q;
  assign w_pf_err   = pf_err_q;
  // The single read port is free in RESP, so it is borrowed to fetch the next line.
  assign w_raddr    = (state_q == RESP) ? w_next_pc[AW+1:2] : req_pc[AW+1:2];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      pc_q <= req_pc;
    end
    if (rst) begin
      pf_valid_q <= 1'b0;
    end else if (w_done) begin
      pf_valid_q <= !(w_load_ok && (load_addr[31:2] == w_next_pc[31:2]));
      pf_tag_q   <= w_next_pc;
      pf_inst_q  <= w_next_err ? NOP : w_rdata;
      pf_err_q   <= w_next_err;
    end else if (w_accept || (w_load_ok && (load_addr[31:2] == pf_tag_q[31:2]))) begin
      pf_valid_q <= 1'b0;
    end
  end
`else
  assign w_pf_hit  = 1'b0;
  assign w_pf_inst = NOP;
  assign w_pf_err  = 1'b0;
  assign w_raddr   = req_pc[AW+1:2];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_inst_q  <= NOP;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            hold_inst_q <= w_req_inst;
            hold_err_q  <= w_req_err;
            if (w_pf_hit) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_inst_q  <= w_pf_inst;
              resp_err_q   <= w_pf_err;
            end else if (LATENCY == 1) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_inst_q  <= w_req_inst;
              resp_err_q   <= w_req_err;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q      <= RESP;
            cnt_q        <= '0;
            resp_valid_q <= 1'b1;
            resp_inst_q  <= hold_inst_q;
            resp_err_q   <= hold_err_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= NOP;
            resp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_inst  = resp_inst_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_resp.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_inst_mem_resp: scoreboard bench for inst_mem_resp                  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_inst_mem_resp;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;
`ifdef INST_MEM_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, resp_valid, resp_ready, resp_err, load_en;
  logic [31:0] req_pc, resp_inst, load_addr, load_data;

  inst_mem_resp #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_inst (resp_inst),
    .resp_err  (resp_err),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0, failures = 0, cyc = 0;
  logic [31:0] mem_m [DEPTH];
  bit          outstanding = 1'b0, pf_ok = 1'b0, seen = 1'b0;
  logic [31:0] pf_pc, pf_inst, cur_pc;
  logic        pf_err;
  int          rr_mode = 0;
  logic [31:0] last_inst = '0;
  logic        last_err = 1'b0;
  int          last_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit bad_pc(input logic [31:0] pc);
    return ((pc % 32'd4) != 32'd0) || ((pc / 32'd4) >= 32'(DEPTH));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  // Reference model: array contents, outstanding request, next-line buffer.
  always @(negedge clk) begin
    exp_t e;
    chk("req_ready", 32'(req_ready), 32'(!rst && !outstanding));
    if (rst) begin
      sbq.delete();
      outstanding = 1'b0;
      pf_ok       = 1'b0;
    end else begin
      if (resp_valid && resp_ready && outstanding) begin
        outstanding = 1'b0;
        pf_ok  = PF_EN;
        pf_pc  = cur_pc + 32'd4;
        pf_err = bad_pc(pf_pc);
        pf_inst = pf_err ? 32'h0 : mem_m[int'(pf_pc >> 2)];
      end
      if (req_valid && req_ready) begin
        if (pf_ok && (req_pc == pf_pc)) begin
          e.inst = pf_inst;
          e.err  = pf_err;
          e.lat  = 1;
        end else begin
          e.err  = bad_pc(req_pc);
          e.inst = e.err ? 32'h0 : mem_m[int'(req_pc >> 2)];
          e.lat  = LATENCY;
        end
        e.acc_cyc = cyc;
        sbq.push_back(e);
        pf_ok       = 1'b0;
        outstanding = 1'b1;
        cur_pc      = req_pc;
      end
    end
    if (load_en && !bad_pc(load_addr)) begin
      mem_m[int'(load_addr >> 2)] = load_data;
      if (pf_ok && ((load_addr >> 2) == (pf_pc >> 2))) pf_ok = 1'b0;
    end
  end

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (rst) seen = 1'b0;
    if (!resp_valid) begin
      chk("idle_inst", resp_inst, 32'h0);
      chk("idle_err", 32'(resp_err), 32'h0);
    end else if (!rst) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_resp got=resp_valid=1 exp=no_response cyc=%0d", cyc);
      end else begin
        chk("resp_inst", resp_inst, sbq[0].inst);
        chk("resp_err", 32'(resp_err), 32'(sbq[0].err));
        if (!seen) begin
          seen     = 1'b1;
          last_lat = cyc - sbq[0].acc_cyc;
          chk("latency", 32'(last_lat), 32'(sbq[0].lat));
        end
        if (resp_ready) begin
          last_inst = resp_inst;
          last_err  = resp_err;
          void'(sbq.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk) #1;
      case (rr_mode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = 1'($urandom_range(0, 1));
        default: resp_ready = 1'b0;
      endcase
    end
  end

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk) #1;
    load_en = 1'b1; load_addr = a; load_data = d;
  endtask

  task automatic send(input logic [31:0] pc, input bit ld = 1'b0,
                      input logic [31:0] la = 32'h0, input logic [31:0] ldd = 32'h0);
    bit got = 1'b0;
    @(posedge clk) #1;
    req_valid = 1'b1; req_pc = pc; load_en = ld; load_addr = la; load_data = ldd;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
    end
    if (!got) chk("accept_timeout", 32'h0, 32'h1);
    @(posedge clk) #1;
    req_valid = 1'b0; load_en = 1'b0;
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = req_ready && (sbq.size() == 0);
    end
    if (!done) chk("resp_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    logic [31:0] last_acc;
    int          r;
    rst = 1'b1; req_valid = 1'b0; req_pc = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
    // Preload is done with rst held high: loads must still land.
    for (int i = 0; i < DEPTH; i++) load_word(32'(i * 4), $urandom);
    load_word(32'h0, 32'h02A33332);
    load_word(32'h4, 32'h0AA33332);
    load_word(32'h8, 32'h22A33332);
    @(posedge clk) #1;
    load_en = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'h1);

    send(32'h4);
    wait_done();
    chk("basic_inst", last_inst, 32'h0AA33332);
    chk("basic_err", 32'(last_err), 32'h0);
    chk("basic_lat", 32'(last_lat), 32'(LATENCY));

    rr_mode = 2;
    send(32'h8);
    for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'h1);
      chk("hold_ready", 32'(req_ready), 32'h0);
      chk("hold_inst", resp_inst, 32'h22A33332);
    end
    rr_mode = 0;
    @(negedge clk);
    chk("release_valid", 32'(resp_valid), 32'h1);
    @(negedge clk);
    chk("release_idle", 32'(req_ready), 32'h1);
    chk("release_done", 32'(resp_valid), 32'h0);

    send(32'h6);
    wait_done();
    chk("misalign_err", 32'(last_err), 32'h1);
    chk("misalign_inst", last_inst, 32'h0);
    send(32'(4 * DEPTH));
    wait_done();
    chk("range_err", 32'(last_err), 32'h1);
    chk("range_inst", last_inst, 32'h0);

    send(32'h0);
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", 32'(req_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_resp_after_abort", 32'(resp_valid), 32'h0);
    end
    send(32'h0);
    wait_done();
    chk("mem0_kept", last_inst, 32'h02A33332);

    send(32'h4, 1'b1, 32'h4, 32'hFFFFFFFF);
    wait_done();
    chk("rbw_old", last_inst, 32'h0AA33332);
    send(32'h4);
    wait_done();
    chk("rbw_new", last_inst, 32'hFFFFFFFF);

    send(32'h0);
    wait_done();
    send(32'h4);
    wait_done();
    chk("seq_lat", 32'(last_lat), PF_EN ? 32'h1 : 32'(LATENCY));
    send(32'h0);
    wait_done();
    load_word(32'h4, 32'h13579BDF);
    @(posedge clk) #1;
    load_en = 1'b0;
    send(32'h4);
    wait_done();
    chk("seq_load_lat", 32'(last_lat), 32'(LATENCY));
    chk("seq_load_inst", last_inst, 32'h13579BDF);

    rr_mode  = 1;
    last_acc = 32'h0;
    acc      = 1'b1;
    for (int n = 0; n < 800; n++) begin
      @(posedge clk) #1;
      rst = ($urandom_range(0, 119) == 0);
      if (acc || !req_valid) begin
        r = $urandom_range(0, 9);
        if (r < 4)       req_pc = last_acc + 32'd4;
        else if (r < 8)  req_pc = 32'($urandom_range(0, DEPTH - 1) * 4);
        else if (r == 8) req_pc = 32'($urandom_range(0, 4 * DEPTH - 1));
        else             req_pc = 32'(4 * DEPTH + $urandom_range(0, 15) * 4);
      end
      req_valid = ($urandom_range(0, 2) != 0);
      load_en   = ($urandom_range(0, 5) == 0);
      load_addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 8 * DEPTH))
                                               : 32'($urandom_range(0, DEPTH - 1) * 4);
      load_data = $urandom;
      @(negedge clk);
      acc = req_valid && req_ready;
      if (acc) last_acc = req_pc;
    end
    @(posedge clk) #1;
    rst = 1'b0; req_valid = 1'b0; load_en = 1'b0; rr_mode = 0;
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_mem_resp.md
INST_MEM_RESP -- requirements
Module: inst_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit instruction words in the array (power of two, 4..1024).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of cycles from request accept to resp_valid (legal 1..4).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the fetch stage presents a PC.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_pc, input, 32 bits: the byte address of the instruction.
REQ-008 SHALL have port resp_valid, output, 1 bit: resp_inst and resp_err are valid.
REQ-009 SHALL have port resp_ready, input, 1 bit: the fetch stage accepts the response.
REQ-010 SHALL have port resp_inst, output, 32 bits: the instruction word.
REQ-011 SHALL have port resp_err, output, 1 bit: the request was misaligned or out of range.
REQ-012 SHALL have ports load_en (input, 1 bit), load_addr (input, 32 bits, byte address) and load_data (input, 32 bits), forming the preload write port.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and RESP; req_ready=1 only in IDLE and not in rst.
REQ-014 SHALL accept a request on req_valid&&req_ready; in that same cycle it captures mem[req_pc[.. :2]] and the error flag into a holding register (read-before-write against a same-cycle load).
REQ-015 SHALL, on accept, go IDLE->RESP if LATENCY==1, otherwise IDLE->WAIT with the counter loaded to LATENCY-1.
REQ-016 SHALL, in WAIT, decrement the counter each cycle and go to RESP when it reaches 1, so that an accept at cycle t gives resp_valid at t+LATENCY.
REQ-017 SHALL, in RESP, hold resp_valid=1 and keep resp_inst/resp_err stable until resp_ready=1, then go to IDLE in the next cycle; at most one request is outstanding.
REQ-018 SHALL flag error when req_pc[1:0]!=0 or the word index is >=DEPTH; on error resp_err=1 and resp_inst=32'h00000000 (NOP).
REQ-019 SHALL write mem on load_en in any state; an invalid load_addr (misaligned or out of range) is ignored; a load never alters an already-captured response.
REQ-020 SHALL drive resp_inst=0 and resp_err=0 whenever resp_valid=0.

Reset
REQ-021 SHALL, on rst, force next state IDLE, resp_valid=0, resp_inst=0, resp_err=0 and counter=0; req_ready=0 during the rst cycle.
REQ-022 SHALL, on rst asserted in WAIT or RESP, discard the transaction with no response issued.
REQ-023 SHALL NOT clear array contents on rst, and SHALL still honour load_en while rst is high.

Configuration
REQ-024 SHALL implement a one-entry prefetch buffer under macro INST_MEM_PREFETCH_EN: when a RESP handshake completes for PC p, the buffer captures mem[p+4] and its error flag and tags it with p+4.
REQ-025 SHALL, with INST_MEM_PREFETCH_EN defined, serve an accepted request whose PC equals a valid buffer tag from the buffer, go directly to RESP (resp_valid at t+1 regardless of LATENCY) and invalidate the buffer.
REQ-026 SHALL, with INST_MEM_PREFETCH_EN defined, invalidate the buffer on rst, on a load to the tagged word, or on a miss.
REQ-027 SHALL, without INST_MEM_PREFETCH_EN, contain no buffer, so that every request takes exactly LATENCY cycles.

Structure
REQ-028 SHALL take the FSM state enum, the NOP constant (32'h00000000) and the instruction width (32) from shared package cpu_pkg.
REQ-029 SHALL use one sub-module, inst_mem_array: a DEPTH x 32 array with one synchronous write port and one combinational read port.

Verification
REQ-030 SHALL verify: preload words 0..2 = 32'h02A33332, 32'h0AA33332, 32'h22A33332, LATENCY=2, request pc=4 -> resp_valid 2 cycles after accept with resp_inst=32'h0AA33332 and resp_err=0.
REQ-031 SHALL verify: hold resp_ready=0 for 3 cycles in RESP -> resp_valid and resp_inst stay stable and req_ready=0; release -> IDLE next cycle.
REQ-032 SHALL verify: req_pc=32'h00000006, then req_pc=4*DEPTH -> both give resp_err=1 and resp_inst=0.
REQ-033 SHALL verify: rst asserted in WAIT -> no resp_valid appears, req_ready=1 the cycle after rst drops, and mem[0] is still 32'h02A33332.
REQ-034 SHALL verify: load_en to word 1 with 32'hFFFFFFFF in the same cycle as an accepted request for pc=4 -> response 32'h0AA33332; a following request for pc=4 -> 32'hFFFFFFFF.
REQ-035 SHALL verify, with INST_MEM_PREFETCH_EN: sequential pc 0 then 4 -> second resp_valid 1 cycle after accept; a load to word 1 between them -> 2-cycle latency and the new data.
